// File: rtl/stage_id_q_if.sv
// Fetch-to-decode handshake bundle for stage_id_q: fetch push side plus the
// decoded head presented to ex. The master is the fetch/ex side, the slave is the queue.
interface stage_id_q_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_ir;
  logic            if_c;
  logic            if_e;
  logic            if_vld;
  logic            if_rdy;
  logic            ex_rdy;
  logic            id_vld;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_ir;
  logic            id_c;
  logic            id_e;
  logic [XLEN-1:0] id_lr;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_dbg;
  logic            id_illreg;
  logic            id_stall;

  modport master (
    output if_pc, if_ir, if_c, if_e, if_vld, ex_rdy,
    input  if_rdy, id_vld, id_pc, id_ir, id_c, id_e, id_lr,
           id_rs1, id_rs2, id_rd, id_dbg, id_illreg, id_stall
  );

  modport slave (
    input  if_pc, if_ir, if_c, if_e, if_vld, ex_rdy,
    output if_rdy, id_vld, id_pc, id_ir, id_c, id_e, id_lr,
           id_rs1, id_rs2, id_rd, id_dbg, id_illreg, id_stall
  );
endinterface

// File: rtl/stage_id_q.sv
// IF->ID instruction queue with load-use scoreboard, flush, debug-halt tagging
// and register-range check. Optional perf counters under STAGE_ID_Q_PERF_EN.
module stage_id_q #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NXREG      = 16,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_haltreq,
  input  logic        jmp,
  input  logic        ld_wb_vld,
  input  logic [4:0]  ld_wb_idx,
  stage_id_q_if.slave bus,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned XIDX_W = 5;
  localparam int unsigned PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(SKID_DEPTH + 1);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [XLEN-1:0]   pc_q [SKID_DEPTH];
  logic [31:0]       ir_q [SKID_DEPTH];
  logic              c_q  [SKID_DEPTH];
  logic              e_q  [SKID_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pend, pend_eff, pend_nxt, wb_mask;
  logic              halt_pend;

  logic              present, if_rdy_int, push, pop;
  logic [XLEN-1:0]   h_pc;
  logic [31:0]       h_ir;
  logic              h_c, h_e;
  logic [4:0]        opcode;
  logic [XIDX_W-1:0] h_rs1, h_rs2, h_rd;
  logic              use_rs1, use_rs2, use_rd;
  logic              hazard, illreg, vld, dbg, ld_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign present    = (count != '0);
  assign if_rdy_int = (count < CNT_W'(SKID_DEPTH));
  assign push       = bus.if_vld & if_rdy_int & ~jmp;
  assign pop        = vld & bus.ex_rdy;

  // Head decode: operand usage, hazard against the scoreboard, range check
  always_comb begin
    h_pc    = '0;
    h_ir    = '0;
    h_c     = 1'b0;
    h_e     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    if (present) begin
      h_pc = pc_q[rd_ptr];
      h_ir = ir_q[rd_ptr];
      h_c  = c_q[rd_ptr];
      h_e  = e_q[rd_ptr];
    end
    opcode = h_ir[6:2];
    h_rs1  = h_ir[19:15];
    h_rs2  = h_ir[24:20];
    h_rd   = h_ir[11:7];
    // Fault entries carry no real instruction, so they use no operands
    if (present && !h_e) begin
      use_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
      use_rs2 = opcode inside {OP_BRANCH, OP_STORE, OP_OP};
      use_rd  = (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP})
              | ((opcode == OP_SYSTEM) && (h_ir[14:12] != 3'b000));
    end
    wb_mask  = ld_wb_vld ? (32'd1 << ld_wb_idx) : 32'd0;
    pend_eff = pend & ~wb_mask;
    hazard   = (use_rs1 && (h_rs1 != '0) && pend_eff[h_rs1])
             | (use_rs2 && (h_rs2 != '0) && pend_eff[h_rs2])
             | (use_rd  && (h_rd  != '0) && pend_eff[h_rd]);
    illreg   = (use_rs1 && (32'(h_rs1) >= NXREG))
             | (use_rs2 && (32'(h_rs2) >= NXREG))
             | (use_rd  && (32'(h_rd)  >= NXREG));
    vld      = present & ~hazard & ~jmp;
    dbg      = present & (halt_pend | dm_haltreq);
    ld_set   = pop & use_rd & (opcode == OP_LOAD) & (h_rd != '0) & ~illreg;
    pend_nxt = pend & ~wb_mask;
    if (ld_set) pend_nxt[h_rd] = 1'b1;
  end

  assign bus.if_rdy    = if_rdy_int;
  assign bus.id_vld    = vld;
  assign bus.id_stall  = present & hazard & ~jmp;
  assign bus.id_pc     = h_pc;
  assign bus.id_ir     = h_ir;
  assign bus.id_c      = h_c;
  assign bus.id_e      = h_e;
  assign bus.id_lr     = present ? (h_pc + (h_c ? XLEN'(2) : XLEN'(4))) : '0;
  assign bus.id_rs1    = h_rs1;
  assign bus.id_rs2    = h_rs2;
  assign bus.id_rd     = h_rd;
  assign bus.id_dbg    = dbg;
  assign bus.id_illreg = illreg;

  // Queue storage, pointers, scoreboard and halt tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pend      <= '0;
      halt_pend <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        pc_q[i] <= '0;
        ir_q[i] <= '0;
        c_q[i]  <= 1'b0;
        e_q[i]  <= 1'b0;
      end
    end else begin
      if (jmp) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_q[wr_ptr] <= bus.if_pc;
          ir_q[wr_ptr] <= bus.if_ir;
          c_q[wr_ptr]  <= bus.if_c;
          e_q[wr_ptr]  <= bus.if_e;
          wr_ptr       <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      pend      <= pend_nxt;
      // A level request re-arms the tag even while the tagged head retires
      halt_pend <= dm_haltreq | (halt_pend & ~(pop & dbg));
    end
  end

`ifdef STAGE_ID_Q_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (present & hazard & ~jmp) stall_cnt <= stall_cnt + 32'd1;
      if (jmp & present)           flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_id_q.sv
// Bench for stage_id_q: directed scenarios then random traffic, checked against a
// queue/scoreboard reference model. Perf expectations follow STAGE_ID_Q_PERF_EN.
module tb_stage_id_q;

  logic        clk = 1'b0;
  logic        rst, dm_haltreq, jmp, ld_wb_vld;
  logic [4:0]  ld_wb_idx;
  logic [31:0] if_pc, if_ir;
  logic        if_c, if_e, if_vld, ex_rdy;
  logic [31:0] p16s, p16f, p32s, p32f;

  always #5 clk = ~clk;

  stage_id_q_if #(.XLEN(32)) b16 ();
  stage_id_q_if #(.XLEN(32)) b32 ();

  assign b16.if_pc = if_pc;  assign b32.if_pc = if_pc;
  assign b16.if_ir = if_ir;  assign b32.if_ir = if_ir;
  assign b16.if_c  = if_c;   assign b32.if_c  = if_c;
  assign b16.if_e  = if_e;   assign b32.if_e  = if_e;
  assign b16.if_vld = if_vld; assign b32.if_vld = if_vld;
  assign b16.ex_rdy = ex_rdy; assign b32.ex_rdy = ex_rdy;

  stage_id_q #(.XLEN(32), .NXREG(16), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .dm_haltreq(dm_haltreq), .jmp(jmp),
    .ld_wb_vld(ld_wb_vld), .ld_wb_idx(ld_wb_idx), .bus(b16),
    .perf_stall_cnt(p16s), .perf_flush_cnt(p16f)
  );

  stage_id_q #(.XLEN(32), .NXREG(32), .SKID_DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .dm_haltreq(dm_haltreq), .jmp(jmp),
    .ld_wb_vld(ld_wb_vld), .ld_wb_idx(ld_wb_idx), .bus(b32),
    .perf_stall_cnt(p32s), .perf_flush_cnt(p32f)
  );

  // Reference model: a plain FIFO of fetched words plus a pending-load bit set
  typedef struct { logic [31:0] pc; logic [31:0] ir; bit c; bit e; } ent_t;
  ent_t        q[$];
  bit   [31:0] pend;
  bit          halt;
  bit   [31:0] m_stall, m_flush;
  int          total = 0;
  int          bad   = 0;

  bit          e_rdy, e_vld, e_stall, e_dbg, e_ill, e_ldset;
  ent_t        h;
  logic [31:0] e_lr;

  localparam int NX = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1,
                                     input int rs2, input logic [2:0] f3);
    return {7'b0, 5'(rs2), 5'(rs1), f3, 5'(rd), op};
  endfunction

  // Which register roles an instruction exercises, from the RISC-V opcode map
  function automatic void roles(input ent_t x, output bit r1, output bit r2, output bit wr);
    logic [6:0] op;
    op = x.ir[6:0];
    r1 = 0; r2 = 0; wr = 0;
    if (x.e) return;
    case (op)
      7'b0110111, 7'b0010111: begin wr = 1; end                 // lui, auipc
      7'b1101111:             begin wr = 1; end                 // jal
      7'b1100111:             begin r1 = 1; wr = 1; end         // jalr
      7'b0000011, 7'b0010011: begin r1 = 1; wr = 1; end         // load, op-imm
      7'b0110011:             begin r1 = 1; r2 = 1; wr = 1; end // op
      7'b0100011, 7'b1100011: begin r1 = 1; r2 = 1; end         // store, branch
      7'b1110011:             begin r1 = 1; wr = (x.ir[14:12] != 0); end
      default:                begin r1 = 1; end
    endcase
  endfunction

  task automatic model_eval();
    bit r1, r2, wr, present;
    bit [31:0] peff;
    int s1, s2, d;
    present = (q.size() != 0);
    e_rdy = (q.size() < 2);
    h = '{pc: 32'h0, ir: 32'h0, c: 0, e: 0};
    if (present) h = q[0];
    roles(h, r1, r2, wr);
    if (!present) begin r1 = 0; r2 = 0; wr = 0; end
    s1 = int'(h.ir[19:15]); s2 = int'(h.ir[24:20]); d = int'(h.ir[11:7]);
    peff = pend;
    if (ld_wb_vld) peff[ld_wb_idx] = 0;
    e_stall = present && !jmp && ((r1 && s1 != 0 && peff[s1]) ||
                                  (r2 && s2 != 0 && peff[s2]) ||
                                  (wr && d  != 0 && peff[d]));
    e_vld   = present && !jmp && !e_stall;
    e_ill   = (r1 && s1 >= NX) || (r2 && s2 >= NX) || (wr && d >= NX);
    e_dbg   = present && (halt || dm_haltreq);
    e_lr    = present ? h.pc + (h.c ? 32'd2 : 32'd4) : 32'd0;
    e_ldset = wr && (h.ir[6:0] == 7'b0000011) && d != 0 && !e_ill;
  endtask

  task automatic model_update();
    bit push, pop;
    push = if_vld && e_rdy && !jmp;
    pop  = e_vld && ex_rdy;
    if (e_stall) m_stall++;
    if (jmp && q.size() != 0) m_flush++;
    if (ld_wb_vld) pend[ld_wb_idx] = 0;
    if (pop && e_ldset) pend[h.ir[11:7]] = 1;
    if (pop && e_dbg) halt = 0;
    if (dm_haltreq) halt = 1;
    if (jmp) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pc: if_pc, ir: if_ir, c: if_c, e: if_e});
    end
  endtask

  task automatic model_reset();
    q.delete(); pend = 0; halt = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Settle combinational outputs, then compare everything against the model
  task automatic settle_check();
    logic [31:0] es, ef;
    #1;
    model_eval();
`ifdef STAGE_ID_Q_PERF_EN
    es = m_stall; ef = m_flush;
`else
    es = 0; ef = 0;
`endif
    chk("if_rdy",    32'(b16.if_rdy),    32'(e_rdy));
    chk("id_vld",    32'(b16.id_vld),    32'(e_vld));
    chk("id_stall",  32'(b16.id_stall),  32'(e_stall));
    chk("id_dbg",    32'(b16.id_dbg),    32'(e_dbg));
    chk("id_illreg", 32'(b16.id_illreg), 32'(e_ill));
    chk("id_pc",     b16.id_pc,          h.pc);
    chk("id_ir",     b16.id_ir,          h.ir);
    chk("id_c",      32'(b16.id_c),      32'(h.c));
    chk("id_e",      32'(b16.id_e),      32'(h.e));
    chk("id_lr",     b16.id_lr,          e_lr);
    chk("id_rs1",    32'(b16.id_rs1),    32'(h.ir[19:15]));
    chk("id_rs2",    32'(b16.id_rs2),    32'(h.ir[24:20]));
    chk("id_rd",     32'(b16.id_rd),     32'(h.ir[11:7]));
    chk("perf_stall", p16s, es);
    chk("perf_flush", p16f, ef);
    chk("illreg_nx32", 32'(b32.id_illreg), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ir, input bit c);
    if_vld = 1; if_pc = pc; if_ir = ir; if_c = c; if_e = 0;
  endtask

  task automatic idle();
    if_vld = 0; if_pc = 0; if_ir = 0; if_c = 0; if_e = 0;
    jmp = 0; dm_haltreq = 0; ld_wb_vld = 0; ld_wb_idx = 0;
  endtask

  function automatic logic [31:0] rnd_ir();
    logic [6:0] ops [10];
    int r;
    ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};
    r = ($urandom_range(0, 9) == 0) ? 31 : 7;
    return mk(ops[$urandom_range(0, 9)], $urandom_range(0, r), $urandom_range(0, r),
              $urandom_range(0, r), 3'($urandom_range(0, 7)));
  endfunction

  initial begin
    rst = 0; ex_rdy = 0;
    idle();
    model_reset();
    #1 rst = 1;
    @(negedge clk);
    settle_check();
    chk("reset_if_rdy", 32'(b16.if_rdy), 32'd1);
    rst = 0;

    // Three back-to-back pushes with ex_rdy=1; link address follows the c flag
    ex_rdy = 1;
    fetch(32'h100, NOP, 0); settle_check(); tick();
    fetch(32'h104, NOP, 1); settle_check(); chk("lr_100", b16.id_lr, 32'h104); tick();
    fetch(32'h106, NOP, 1); settle_check(); chk("lr_104", b16.id_lr, 32'h106); tick();
    idle(); settle_check(); chk("lr_106", b16.id_lr, 32'h108); tick();
    settle_check(); tick();

    // Backpressure: third offer held until the queue drains
    ex_rdy = 0;
    fetch(32'h300, NOP, 0); settle_check(); tick();
    fetch(32'h304, NOP, 0); settle_check(); tick();
    fetch(32'h308, NOP, 0); settle_check(); chk("full_rdy", 32'(b16.if_rdy), 32'd0); tick();
    ex_rdy = 1; settle_check(); chk("drain0", b16.id_pc, 32'h300); tick();
    settle_check(); chk("drain1", b16.id_pc, 32'h304); tick();
    idle(); settle_check(); chk("drain2", b16.id_pc, 32'h308); tick();
    settle_check(); tick();

    // Load-use: lw x5 then add x6,x5,x1; writeback releases in the same cycle
    fetch(32'h400, mk(7'b0000011, 5, 1, 0, 3'b010), 0); settle_check(); tick();
    fetch(32'h404, mk(7'b0110011, 6, 5, 1, 3'b000), 0); settle_check(); tick();
    idle(); settle_check(); chk("lu_stall", 32'(b16.id_stall), 32'd1); tick();
    ld_wb_vld = 1; ld_wb_idx = 5;
    settle_check(); chk("lu_release", 32'(b16.id_vld), 32'd1); tick();
    idle();

    // Flush a full queue while a load to x5 is outstanding
    fetch(32'h500, mk(7'b0000011, 5, 2, 0, 3'b010), 0); settle_check(); tick();
    fetch(32'h504, NOP, 0); settle_check(); tick();
    ex_rdy = 0;
    fetch(32'h508, NOP, 0); settle_check(); tick();
    idle(); jmp = 1; settle_check(); chk("jmp_vld", 32'(b16.id_vld), 32'd0); tick();
    jmp = 0; settle_check(); chk("jmp_rdy", 32'(b16.if_rdy), 32'd1); tick();
    ex_rdy = 1;
    fetch(32'h600, mk(7'b0110011, 6, 5, 1, 3'b000), 0); settle_check(); tick();
    idle(); settle_check(); chk("pend_kept", 32'(b16.id_stall), 32'd1); tick();
    ld_wb_vld = 1; ld_wb_idx = 5; settle_check(); tick();
    idle(); settle_check(); tick();

    // Debug request raised while empty tags the next head only
    dm_haltreq = 1; settle_check(); tick();
    dm_haltreq = 0; settle_check(); tick();
    ex_rdy = 0;
    fetch(32'h200, NOP, 0); settle_check(); tick();
    fetch(32'h204, NOP, 0); settle_check(); chk("dbg_tag", 32'(b16.id_dbg), 32'd1); tick();
    idle(); ex_rdy = 1; settle_check(); tick();
    settle_check(); chk("dbg_next", 32'(b16.id_dbg), 32'd0); tick();
    settle_check(); tick();

    // Out-of-range register on RV32E still issues and sets no scoreboard bit
    fetch(32'h700, mk(7'b0110011, 17, 1, 2, 3'b000), 0); settle_check(); tick();
    fetch(32'h704, mk(7'b0000011, 17, 1, 0, 3'b010), 0); settle_check();
    chk("ill16", 32'(b16.id_illreg), 32'd1); chk("ill_vld", 32'(b16.id_vld), 32'd1); tick();
    fetch(32'h708, mk(7'b0110011, 1, 17, 2, 3'b000), 0); settle_check(); tick();
    idle(); settle_check(); tick();

    // Random traffic with one asynchronous reset in the middle
    for (int n = 0; n < 700; n++) begin
      if (n == 350) begin
        rst = 1; idle(); ex_rdy = 0;
        model_reset();
        settle_check();
        @(negedge clk);
        rst = 0;
      end
      if_vld     = ($urandom_range(0, 9) < 7);
      if_pc      = {$urandom_range(0, 32'hFFFF), 1'b0, 1'b0} | ($urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : 32'h0);
      if_ir      = rnd_ir();
      if_c       = ($urandom_range(0, 9) < 3);
      if_e       = ($urandom_range(0, 19) == 0);
      ex_rdy     = ($urandom_range(0, 9) < 7);
      jmp        = ($urandom_range(0, 19) == 0);
      dm_haltreq = ($urandom_range(0, 29) == 0);
      ld_wb_vld  = ($urandom_range(0, 9) < 3);
      ld_wb_idx  = 5'($urandom_range(0, 7));
      settle_check();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_id_q.md
Name: stage_id_q

Overview:
- Parametrised IF→ID boundary for the femto core: valid/ready instruction queue of SKID_DEPTH entries replacing the single IF/ID flop.
- Adds a load-use scoreboard with hazard stall, jmp flush, sticky debug-halt tagging and register-index range checking.
- Sits between stage_if and the decode/ex logic; emits register indices, link address and hazard-free valid.

Parameters:
XLEN, 32, PC/link width.
NXREG, 16, architectural x-register count (16 = RV32E, 32 = RV32I); index width XIDX_W = 5 always, range checked against NXREG.
SKID_DEPTH, 2, queue entries (1 or 2).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
dm_haltreq  in  1  debug halt request (level)
jmp  in  1  pipeline flush (taken jump/trap)
if_pc  in  XLEN  fetched PC
if_ir  in  32  fetched instruction (expanded if compressed)
if_c  in  1  compressed flag
if_e  in  1  ibus fault flag
if_vld  in  1  fetch valid
if_rdy  out  1  queue can accept
ex_rdy  in  1  downstream accepts head
ld_wb_vld  in  1  load writeback this cycle
ld_wb_idx  in  5  load writeback rd
id_vld  out  1  head valid and hazard-free
id_pc  out  XLEN  head PC
id_ir  out  32  head instruction
id_c  out  1  head compressed flag
id_e  out  1  head fault flag
id_lr  out  XLEN  id_pc + (id_c ? 2 : 4), modulo 2^XLEN
id_rs1  out  5  ir[19:15]
id_rs2  out  5  ir[24:20]
id_rd  out  5  ir[11:7]
id_dbg  out  1  head tagged for debug halt
id_illreg  out  1  head uses an index >= NXREG
id_stall  out  1  head present but blocked by hazard
perf_stall_cnt  out  32  stall-cycle counter (optional feature)
perf_flush_cnt  out  32  flush counter (optional feature)

Behaviour:
- Reset (async on rst=1): queue empty, scoreboard pend[31:0]=0, halt_pend=0. Outputs: if_rdy=1; id_vld, id_dbg, id_illreg, id_stall=0; id_pc/id_ir/id_lr/indices=0; counters=0.
- Queue: circular, count 0..SKID_DEPTH. if_rdy = (count<SKID_DEPTH), driven from registered count only. Push = if_vld & if_rdy & ~jmp. Pop = id_vld & ex_rdy. Push and pop in the same cycle when full: no push (if_rdy already 0). Push and pop when count=1: count unchanged, new entry becomes head next cycle. Zero-latency path not allowed: a pushed entry is visible at head one cycle later.
- Head fields come straight from storage registers; no combinational path from if_* to id_*.
- Operand use by opcode[6:2]: rs1 used by all except LUI, AUIPC, JAL; rs2 used by BRANCH, STORE, OP; rd written by LUI, AUIPC, JAL, JALR, LOAD, IMMCAL, OP, SYSTEM with funct3!=0. Index 0 is never hazarded.
- Hazard = (used rs1 & pend_eff[rs1]) | (used rs2 & pend_eff[rs2]) | (writes rd & pend_eff[rd]), where pend_eff = pend with bit ld_wb_idx cleared when ld_wb_vld=1. Same-cycle writeback releases the stall; the regfile bypass covers the data.
- id_vld = (count!=0) & ~hazard & ~jmp. id_stall = (count!=0) & hazard & ~jmp.
- Scoreboard update each clk: clear pend[ld_wb_idx] if ld_wb_vld; then set pend[id_rd] if Pop & LOAD & id_rd!=0 & ~id_illreg. When set and clear hit the same index, set wins.
- jmp=1: count->0, write pointers realigned, no pop, no push. pend is NOT cleared because outstanding loads still return. halt_pend is kept.
- Debug: halt_pend <= 1 on dm_haltreq; id_dbg = head present & (halt_pend | dm_haltreq). halt_pend clears on Pop of the tagged head. A request raised with an empty queue stays pending until the next head.
- id_illreg = head present & any used index >= NXREG. The instruction still issues; ex raises illegal instruction. With NXREG=32, id_illreg is constantly 0.
- Fault entries (id_e=1): no operand use, no hazard, no scoreboard set.
- rst asserted mid-operation: everything returns to reset values immediately; in-flight loads are forgotten.

Optional Feature:
- Macro STAGE_ID_Q_PERF_EN.
- Defined: perf_stall_cnt increments on every cycle with id_stall=1. perf_flush_cnt increments on every cycle with jmp=1 and count!=0. Both wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: both ports are tied to constant 0 and no counter flops exist.

Test Plan:
- Reset, then push 3 back-to-back with ex_rdy=1, SKID_DEPTH=2 -> if_rdy stays 1; id_vld rises one cycle after each push; pc 0x100, 0x104, 0x106 (c=1) give id_lr 0x104, 0x106, 0x108.
- ex_rdy=0 with 3 pushes offered -> if_rdy=0 after the 2nd accept; the 3rd is held; ex_rdy=1 drains in order.
- lw x5 popped, then add x6,x5,x1 at head -> id_stall=1, id_vld=0; pend[5]=1; ld_wb_vld=1, idx=5 -> id_vld=1 in that same cycle.
- Queue full, jmp=1 -> next cycle count=0, if_rdy=1, id_vld=0; pend[5] from an earlier load still 1; perf_flush_cnt=1 (macro on).
- dm_haltreq pulsed with the queue empty, then push pc 0x200 -> that head shows id_dbg=1; it clears after pop; the following instruction shows id_dbg=0.
- NXREG=16, add x17,x1,x2 -> id_illreg=1, id_vld=1, no scoreboard bit set; with NXREG=32 -> id_illreg=0.
